logic_op_unit: RTL and testbench
================================

LOGIC_OP_UNIT -- requirements
Module: logic_op_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SLICE, default 8, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE, else elaboration fails.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A  input  WIDTH  operand A, unsigned.
REQ-006 B  input  WIDTH  operand B, unsigned.
REQ-007 log_op  input  3  operation select, encoding per REQ-013.
REQ-008 start  input  1  request; sampled only in IDLE.
REQ-009 C  output  WIDTH  registered result.
REQ-010 finish  output  1  one-cycle pulse, C valid.
REQ-011 busy  output  1  high in BUSY and DONE states.
REQ-012 zero  output  1  registered; 1 when final C is all zeros, updated with finish.

Function
REQ-013 Encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 NOT A (B ignored), 111 pass B.
REQ-014 FSM states IDLE, BUSY, DONE; IDLE->BUSY on start; BUSY->DONE on last slice; DONE->IDLE unconditionally next cycle.
REQ-015 On the edge where IDLE and start=1, A, B, log_op SHALL be latched into internal registers and slice counter cleared to 0; later input changes SHALL not affect the result.
REQ-016 In BUSY, each edge SHALL compute slice cnt (bits cnt*SLICE+SLICE-1 .. cnt*SLICE) from latched operands, write it into C, increment cnt; N = WIDTH/SLICE edges total.
REQ-017 C bits not yet written in the current operation SHALL hold their previous values; C SHALL not be cleared at start.
REQ-018 The edge writing slice N-1 SHALL set finish=1, update zero, and enter DONE; finish SHALL be 0 in every other cycle.
REQ-019 Latency: finish high exactly N cycles after the start-sampling edge (N=4 at defaults); back-to-back throughput one operation per N+2 cycles.
REQ-020 start while busy=1 SHALL be ignored, not queued.
REQ-021 start held high continuously SHALL launch a new operation on each IDLE cycle.
REQ-022 C and zero SHALL hold their final values until overwritten by a subsequent operation or reset.
REQ-023 SLICE=WIDTH is legal: N=1, single BUSY cycle.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, C=0, finish=0, busy=0, zero=1, counter and latched operands 0, independent of clk.
REQ-025 Reset mid-operation SHALL abandon the operation with no finish pulse; first start after rst deassertion SHALL behave normally.

Structure
REQ-026 A shared package SHALL hold the log_op encoding enum (3-bit) and the FSM state enum; WIDTH/SLICE remain module parameters.
REQ-027 One sub-module SHALL exist: logic_slice, parameterised by SLICE, purely combinational, mapping slice of A, slice of B, log_op to result slice; logic_op_unit instantiates it once.
REQ-028 Counter width SHALL be $clog2(N) with minimum 1 bit.

Verification
REQ-029 Defaults, A=0xF0F0_1234, B=0x0FF0_FFFF, log_op=000, start pulse -> finish exactly 4 cycles later, C=0x00F0_1234, zero=0.
REQ-030 A=0xFFFF_FFFF, B=0xFFFF_FFFF, log_op=010 -> C=0x0000_0000, zero=1; then log_op=011 with A=B=0 -> C=0xFFFF_FFFF, zero=0.
REQ-031 Start with log_op=110, A=0x1234_5678; change A to 0 and pulse start on cycle 2 -> single finish, C=0xEDCB_A987, second start ignored.
REQ-032 Assert rst 2 cycles after start -> C=0, busy=0, no finish; next operation (log_op=111, B=0xDEAD_BEEF) -> C=0xDEAD_BEEF.
REQ-033 WIDTH=16, SLICE=16, A=0xAAAA, B=0x5555, log_op=001 -> finish 1 cycle after start, C=0xFFFF; log_op=101 -> C=0x0000, zero=1.
REQ-034 start held high for 20 cycles at defaults -> finish every 6 cycles, busy low exactly one cycle between operations.

Source files
------------

// File: rtl/logic_op_unit_pkg.sv
// Shared types for the slice-serial logic operation unit: operation
// encoding, controller states and the per-bit operation helper.
package logic_op_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } log_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_bit(input log_op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_NAND:  r = ~(a & b);
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      default:  r = b;
    endcase
    return r;
  endfunction

  // Slice counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logic_op_unit_slice.sv
// Combinational slice datapath: applies the selected logic operation
// bitwise across one SLICE-wide chunk of the operands.
module logic_slice
  import logic_op_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  log_op_e          log_op,
  output logic [SLICE-1:0] y
);

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign y[i] = op_bit(log_op, a[i], b[i]);
  end

endmodule

// File: rtl/logic_op_unit.sv
// Slice-serial logic unit: latches a request, then produces one SLICE-wide
// chunk of C per clock, pulsing finish on the edge that writes the last chunk.
module logic_op_unit
  import logic_op_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       log_op,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             finish,
  output logic             busy,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("logic_op_unit: WIDTH must be a positive multiple of SLICE");
  end

  typedef struct packed {
    logic [N-1:0][SLICE-1:0] a;
    logic [N-1:0][SLICE-1:0] b;
    log_op_e                 op;
  } req_t;

  state_e                  state;
  req_t                    req_q;
  logic [CW-1:0]           cnt;
  logic [N-1:0][SLICE-1:0] c_q;
  logic [N-1:0][SLICE-1:0] c_nxt;
  logic [SLICE-1:0]        y;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a      (req_q.a[cnt]),
    .b      (req_q.b[cnt]),
    .log_op (req_q.op),
    .y      (y)
  );

  // Only the current chunk changes; untouched chunks keep the last result.
  always_comb begin
    c_nxt      = c_q;
    c_nxt[cnt] = y;
  end

  assign C = c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= '0;
      cnt    <= '0;
      c_q    <= '0;
      finish <= 1'b0;
      busy   <= 1'b0;
      zero   <= 1'b1;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_q.a  <= A;
            req_q.b  <= B;
            req_q.op <= log_op_e'(log_op);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          c_q <= c_nxt;
          if (cnt == LAST) begin
            cnt    <= '0;
            finish <= 1'b1;
            zero   <= (c_nxt == '0);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed + randomized bench for logic_op_unit (32/8 and 16/16 configurations)
// against a word-level reference model.
module tb_logic_op_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B, C;
  logic [2:0]  log_op;
  logic        start, finish, busy, zero;

  logic [15:0] a16, b16, c16;
  logic [2:0]  op16;
  logic        start16, finish16, busy16, zero16;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_c;
  logic [31:0] ref_v;
  int          fin_cnt;

  always #5 clk = ~clk;

  logic_op_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .log_op(log_op), .start(start),
    .C(C), .finish(finish), .busy(busy), .zero(zero)
  );

  logic_op_unit #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .log_op(op16), .start(start16),
    .C(c16), .finish(finish16), .busy(busy16), .zero(zero16)
  );

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 32-bit unit, checking every cycle: partial C,
  // finish timing, busy, zero, and that the request was latched at start.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input string tag);
    logic [31:0] nw, prev, part;
    logic [63:0] m;
    nw   = model(a, b, op);
    prev = exp_c;
    A = a; B = b; log_op = op; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; log_op = 3'($urandom);
    chk({tag, ".busy0"}, busy, 1'b1);
    chk({tag, ".fin0"}, finish, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      m    = (64'd1 << (8 * k)) - 64'd1;
      part = (nw & m[31:0]) | (prev & ~m[31:0]);
      chk($sformatf("%s.c%0d", tag, k), C, part);
      chk($sformatf("%s.fin%0d", tag, k), finish, (k == 4));
    end
    chk({tag, ".zero"}, zero, (nw == 32'd0));
    chk({tag, ".busy_done"}, busy, 1'b1);
    tick();
    chk({tag, ".fin_off"}, finish, 1'b0);
    chk({tag, ".busy_off"}, busy, 1'b0);
    chk({tag, ".c_hold"}, C, nw);
    exp_c = nw;
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; log_op = '0; start = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; start16 = 1'b0;
    exp_c = '0;
    #3;
    chk("rst.c", C, 32'd0);
    chk("rst.fin", finish, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.zero", zero, 1'b1);
    chk("rst.zero16", zero16, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, "and");
    chk("and.c", C, 32'h00F0_1234);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, "xor");
    chk("xor.c", C, 32'h0000_0000);
    chk("xor.z", zero, 1'b1);
    run_op(32'h0, 32'h0, 3'b011, "nor");
    chk("nor.c", C, 32'hFFFF_FFFF);
    chk("nor.z", zero, 1'b0);

    // Start while busy must be ignored and inputs changed after start unused.
    A = 32'h1234_5678; B = $urandom; log_op = 3'b110; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 32'h0; start = 1'b1;
    fin_cnt = 0;
    tick();
    start = 1'b0;
    fin_cnt += int'(finish);
    for (int k = 0; k < 8; k++) begin
      tick();
      fin_cnt += int'(finish);
    end
    chk("ign.fins", 64'(fin_cnt), 64'd1);
    chk("ign.c", C, 32'hEDCB_A987);
    chk("ign.busy", busy, 1'b0);
    exp_c = 32'hEDCB_A987;

    // Reset mid-operation: immediate clear, no finish afterwards.
    A = $urandom; B = $urandom; log_op = 3'($urandom); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst.c", C, 32'd0);
    chk("mrst.busy", busy, 1'b0);
    chk("mrst.fin", finish, 1'b0);
    chk("mrst.zero", zero, 1'b1);
    tick();
    rst = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      fin_cnt += int'(finish);
    end
    chk("mrst.nofin", 64'(fin_cnt), 64'd0);
    exp_c = 32'd0;
    run_op($urandom, 32'hDEAD_BEEF, 3'b111, "passb");
    chk("passb.c", C, 32'hDEAD_BEEF);

    // Continuous start: one operation every N+2 = 6 cycles.
    A = $urandom; B = $urandom; log_op = 3'($urandom);
    ref_v = model(A, B, log_op);
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("cont.fin%0d", k), finish, ((k % 6) == 4));
      chk($sformatf("cont.busy%0d", k), busy, ((k % 6) != 5));
      if ((k % 6) == 4) chk($sformatf("cont.c%0d", k), C, ref_v);
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("cont.idle", busy, 1'b0);
    exp_c = ref_v;

    for (int i = 0; i < 12; i++)
      run_op($urandom, $urandom, 3'($urandom), $sformatf("rnd%0d", i));

    // Single-slice configuration.
    a16 = 16'hAAAA; b16 = 16'h5555; op16 = 3'b001; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("w16.busy", busy16, 1'b1);
    chk("w16.fin0", finish16, 1'b0);
    tick();
    chk("w16.fin1", finish16, 1'b1);
    chk("w16.or", c16, 16'hFFFF);
    chk("w16.orz", zero16, 1'b0);
    tick();
    chk("w16.finoff", finish16, 1'b0);
    tick();
    op16 = 3'b101; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    chk("w16.fin2", finish16, 1'b1);
    chk("w16.xnor", c16, 16'h0000);
    chk("w16.xnorz", zero16, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
